// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: state encoding,
// redirect payload and the redirect selection helper.
package pc_fetch_sequencer_pkg;

    localparam int unsigned XLEN              = 32;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] target;
    } redirect_t;

    // Jump wins over a taken branch when both arrive in the same cycle.
    function automatic redirect_t select_redirect(
        input logic            jump,
        input logic [XLEN-1:0] jump_target,
        input logic            branch_taken,
        input logic [XLEN-1:0] branch_target
    );
        redirect_t r;
        r.valid  = jump | branch_taken;
        r.target = jump ? jump_target : branch_target;
        return r;
    endfunction

    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-stage bundle: control/redirect inputs, instruction-memory handshake
// and the decode-facing instruction outputs.
interface pc_fetch_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall_i;
    logic            branch_taken_i;
    logic [XLEN-1:0] branch_target_i;
    logic            jump_i;
    logic [XLEN-1:0] jump_target_i;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;

    logic            instr_valid_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic            misaligned_o;

    modport master (
        input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output imem_req_o, imem_addr_o,
        output instr_valid_o, instr_o, instr_pc_o, pc_plus4_o, misaligned_o
    );

    modport slave (
        output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o,
        input  instr_valid_o, instr_o, instr_pc_o, pc_plus4_o, misaligned_o
    );
endinterface

// File: rtl/pc_fetch_sequencer_adder_32bit.sv
// 32-bit adder used to form the sequential PC; carry-out is not needed
// because the PC wraps modulo 2^32.
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum
);

    assign sum = a + b + 32'(cin);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter / instruction-fetch stage: issues req/gnt/rvalid fetches,
// presents instruction + PC to decode, handles stall, redirect and kill.
module pc_fetch_sequencer #(
    parameter int unsigned    XLEN      = pc_fetch_sequencer_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = pc_fetch_sequencer_pkg::RESET_VEC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pc_fetch_sequencer_if.master   bus
);
    import pc_fetch_sequencer_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;
    logic            kill_q, kill_d;
    logic            misaligned_q, misaligned_d;

    redirect_t       redir;
    logic            redir_ok;
    logic            redir_bad;

    adder_32bit u_pc_adder (
        .a   (pc_q),
        .b   (32'd4),
        .cin (1'b0),
        .sum (pc_plus4)
    );

    // Redirects are ignored while the stage is coming out of reset.
    always_comb begin
        redir     = select_redirect(bus.jump_i, bus.jump_target_i,
                                    bus.branch_taken_i, bus.branch_target_i);
        redir_ok  = 1'b0;
        redir_bad = 1'b0;
        if (state_q != RESET && redir.valid) begin
            redir_ok  = is_aligned(redir.target);
            redir_bad = ~is_aligned(redir.target);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RESET: state_d = REQ;
            REQ:   if (bus.imem_gnt_i) state_d = WAIT;
            WAIT: begin
                // A killed or redirected response is dropped and fetch restarts.
                if (bus.imem_rvalid_i) begin
                    state_d = (kill_q || redir_ok) ? REQ : HOLD;
                end
            end
            HOLD:  if (redir_ok || !bus.stall_i) state_d = REQ;
            default: state_d = RESET;
        endcase
    end

    always_comb begin
        bus.imem_req_o    = (state_q == REQ);
        bus.imem_addr_o   = pc_q;
        bus.pc_plus4_o    = pc_plus4;
        bus.instr_valid_o = valid_q;
        bus.instr_o       = instr_q;
        bus.instr_pc_o    = instr_pc_q;
        bus.misaligned_o  = misaligned_q;
    end

    // Datapath next-values: PC selection, capture of returned data, kill tracking.
    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        valid_d      = valid_q;
        kill_d       = kill_q;
        misaligned_d = redir_bad;

        unique case (state_q)
            RESET: begin
                kill_d  = 1'b0;
                valid_d = 1'b0;
            end
            REQ: begin
                if (redir_ok) begin
                    pc_d    = redir.target;
                    valid_d = 1'b0;
                    kill_d  = bus.imem_gnt_i;
                end
            end
            WAIT: begin
                if (redir_ok) begin
                    pc_d    = redir.target;
                    valid_d = 1'b0;
                end
                if (bus.imem_rvalid_i) begin
                    kill_d = 1'b0;
                    if (!kill_q && !redir_ok) begin
                        instr_d    = bus.imem_rdata_i;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                    end
                end else if (redir_ok) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                kill_d = 1'b0;
                if (redir_ok) begin
                    pc_d    = redir.target;
                    valid_d = 1'b0;
                end else if (!bus.stall_i) begin
                    pc_d    = pc_plus4;
                    valid_d = 1'b0;
                end
            end
            default: begin
                kill_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_VEC;
            instr_q      <= NOP_INSTR;
            instr_pc_q   <= RESET_VEC;
            valid_q      <= 1'b0;
            kill_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            valid_q      <= valid_d;
            kill_q       <= kill_d;
            misaligned_q <= misaligned_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a scoreboard queue holds the expected
// (pc, instr) pairs; each new instr_valid_o presentation pops and compares one.
module tb_pc_fetch_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   rel_cyc;
    bit   prev_valid = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_fetch_sequencer_if #(.XLEN(32)) bus ();
    pc_fetch_sequencer_if #(.XLEN(32)) bus2 ();

    pc_fetch_sequencer #(.XLEN(32), .RESET_VEC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    pc_fetch_sequencer #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2.master)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance one cycle, sample #1 after the edge, score new presentations.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.instr_valid_o === 1'b1 && !prev_valid) begin
            n_vec++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_valid: observed valid at pc %h expected no valid",
                       bus.instr_pc_o);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_instr_pc", bus.instr_pc_o, e.pc);
                chk("sb_instr", bus.instr_o, e.instr);
            end
        end
        prev_valid = (bus.instr_valid_o === 1'b1);
    endtask

    // DUT must be in REQ; withhold gnt, grant, return data one cycle later.
    task automatic do_fetch(input int gnt_wait, input logic [31:0] exp_addr);
        chk("req_asserted", 32'(bus.imem_req_o), 32'd1);
        chk("fetch_addr", bus.imem_addr_o, exp_addr);
        for (int i = 0; i < gnt_wait; i++) begin
            bus.imem_gnt_i = 1'b0;
            tick();
            chk("addr_stable", bus.imem_addr_o, exp_addr);
            chk("no_valid_before_rvalid", 32'(bus.instr_valid_o), 32'd0);
        end
        bus.imem_gnt_i = 1'b1;
        tick();
        bus.imem_gnt_i = 1'b0;
        chk("req_dropped_in_wait", 32'(bus.imem_req_o), 32'd0);
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = instr_of(exp_addr);
        sb.push_back('{exp_addr, instr_of(exp_addr)});
        tick();
        bus.imem_rvalid_i = 1'b0;
        chk("valid_after_rvalid", 32'(bus.instr_valid_o), 32'd1);
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        bus.stall_i = 1'b0;  bus.branch_taken_i = 1'b0; bus.branch_target_i = '0;
        bus.jump_i  = 1'b0;  bus.jump_target_i  = '0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        bus2.stall_i = 1'b0; bus2.branch_taken_i = 1'b0; bus2.branch_target_i = '0;
        bus2.jump_i  = 1'b0; bus2.jump_target_i  = '0;
        bus2.imem_gnt_i = 1'b0; bus2.imem_rvalid_i = 1'b0; bus2.imem_rdata_i = '0;

        // Reset state
        tick();
        tick();
        chk("rst_req", 32'(bus.imem_req_o), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("rst_instr", bus.instr_o, NOP);
        chk("rst_instr_pc", bus.instr_pc_o, 32'h0);
        chk("rst_misaligned", 32'(bus.misaligned_o), 32'd0);
        chk("rst_addr", bus.imem_addr_o, 32'h0);
        chk("rst_pc_plus4", bus.pc_plus4_o, 32'h4);

        // Sequential fetch, first valid three cycles after release
        rst_n   = 1'b1;
        rel_cyc = cyc;
        tick();
        do_fetch(0, 32'h0);
        chk("first_valid_latency", 32'(cyc - rel_cyc), 32'd3);
        tick();
        do_fetch(0, 32'h4);
        tick();
        do_fetch(0, 32'h8);

        // Grant withheld four cycles
        tick();
        do_fetch(4, 32'hC);

        // Stall in HOLD keeps the presented instruction
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(bus.instr_valid_o), 32'd1);
            chk("stall_instr_pc", bus.instr_pc_o, 32'hC);
            chk("stall_instr", bus.instr_o, instr_of(32'hC));
            chk("stall_no_req", 32'(bus.imem_req_o), 32'd0);
        end
        bus.stall_i = 1'b0;
        tick();

        // Jump during WAIT kills the in-flight response
        chk("pre_jump_addr", bus.imem_addr_o, 32'h10);
        bus.imem_gnt_i = 1'b1;
        tick();
        bus.imem_gnt_i    = 1'b0;
        bus.jump_i        = 1'b1;
        bus.jump_target_i = 32'h100;
        tick();
        bus.jump_i = 1'b0;
        chk("kill_still_wait", 32'(bus.imem_req_o), 32'd0);
        chk("kill_pc", bus.imem_addr_o, 32'h100);
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = instr_of(32'h10);
        tick();
        bus.imem_rvalid_i = 1'b0;
        chk("kill_dropped", 32'(bus.instr_valid_o), 32'd0);
        chk("kill_req", 32'(bus.imem_req_o), 32'd1);
        do_fetch(0, 32'h100);

        // Jump beats branch in the same cycle (redirect in REQ)
        tick();
        chk("pre_prio_addr", bus.imem_addr_o, 32'h104);
        bus.jump_i = 1'b1;         bus.jump_target_i   = 32'h200;
        bus.branch_taken_i = 1'b1; bus.branch_target_i = 32'h300;
        tick();
        bus.jump_i = 1'b0; bus.branch_taken_i = 1'b0;
        chk("prio_req", 32'(bus.imem_req_o), 32'd1);
        chk("prio_addr", bus.imem_addr_o, 32'h200);
        do_fetch(0, 32'h200);

        // Misaligned branch target: one-cycle pulse, sequential PC
        bus.branch_taken_i  = 1'b1;
        bus.branch_target_i = 32'h102;
        tick();
        bus.branch_taken_i = 1'b0;
        chk("misaligned_pulse", 32'(bus.misaligned_o), 32'd1);
        chk("misaligned_seq_addr", bus.imem_addr_o, 32'h204);
        tick();
        chk("misaligned_one_cycle", 32'(bus.misaligned_o), 32'd0);
        chk("misaligned_addr_hold", bus.imem_addr_o, 32'h204);
        do_fetch(0, 32'h204);

        // Redirect and grant in the same REQ cycle
        tick();
        bus.imem_gnt_i    = 1'b1;
        bus.jump_i        = 1'b1;
        bus.jump_target_i = 32'h400;
        tick();
        bus.imem_gnt_i = 1'b0;
        bus.jump_i     = 1'b0;
        chk("gnt_redir_wait", 32'(bus.imem_req_o), 32'd0);
        chk("gnt_redir_pc", bus.imem_addr_o, 32'h400);
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = instr_of(32'h208);
        tick();
        bus.imem_rvalid_i = 1'b0;
        chk("gnt_redir_dropped", 32'(bus.instr_valid_o), 32'd0);
        chk("gnt_redir_addr", bus.imem_addr_o, 32'h400);
        do_fetch(0, 32'h400);

        // Reset during WAIT; late rvalid ignored
        tick();
        bus.imem_gnt_i = 1'b1;
        tick();
        bus.imem_gnt_i = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midrst_req", 32'(bus.imem_req_o), 32'd0);
        chk("midrst_instr", bus.instr_o, NOP);
        chk("midrst_instr_pc", bus.instr_pc_o, 32'h0);
        rst_n = 1'b1;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = instr_of(32'h404);
        tick();
        bus.imem_rvalid_i = 1'b0;
        chk("late_rvalid_ignored", 32'(bus.instr_valid_o), 32'd0);
        chk("late_rvalid_instr", bus.instr_o, NOP);
        chk("restart_addr", bus.imem_addr_o, 32'h0);
        do_fetch(0, 32'h0);

        // PC wrap from RESET_VEC 0xFFFF_FFFC
        chk("wrap_rst_addr", bus2.imem_addr_o, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", bus2.pc_plus4_o, 32'h0);
        chk("wrap_rst_instr_pc", bus2.instr_pc_o, 32'hFFFF_FFFC);
        rst2_n = 1'b1;
        tick();
        chk("wrap_req", 32'(bus2.imem_req_o), 32'd1);
        bus2.imem_gnt_i = 1'b1;
        tick();
        bus2.imem_gnt_i    = 1'b0;
        bus2.imem_rvalid_i = 1'b1;
        bus2.imem_rdata_i  = instr_of(32'hFFFF_FFFC);
        tick();
        bus2.imem_rvalid_i = 1'b0;
        chk("wrap_valid", 32'(bus2.instr_valid_o), 32'd1);
        chk("wrap_instr_pc", bus2.instr_pc_o, 32'hFFFF_FFFC);
        chk("wrap_instr", bus2.instr_o, instr_of(32'hFFFF_FFFC));
        tick();
        chk("wrap_second_req", 32'(bus2.imem_req_o), 32'd1);
        chk("wrap_second_addr", bus2.imem_addr_o, 32'h0);
        chk("wrap_second_plus4", bus2.pc_plus4_o, 32'h4);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
